cacheline_adapter: RTL

//  Memory-side responder for the cache's 256-bit dfp line interface. Accepts one line read or write

---
 rtl/cacheline_adapter_types.sv | 35 +++
 rtl/cacheline_adapter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_types.sv
// ----------------------------------------------------------------------------
// cacheline_adapter_types
//   Shared types and geometry for the cache-line to burst-memory adapter.
//   - adapter_state_t : FSM encoding (IDLE, RD_REQ, RD_DATA, WR, RESP)
//   - LINE_WIDTH / BEAT_WIDTH / ADDR_WIDTH : interface widths
//   - BEATS       : beats per line (LINE_WIDTH / BEAT_WIDTH, power of 2)
//   - OFFSET_BITS : byte-offset bits inside one line
//   - CNT_WIDTH / LAST_BEAT : beat counter geometry
//   - line_align() : clears the in-line byte offset of an address
// ----------------------------------------------------------------------------
package cacheline_adapter_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH   = $clog2(BEATS);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } adapter_state_t;

  // Masking (rather than slicing) keeps every address bit referenced.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    line_align = addr & ~{{(ADDR_WIDTH - OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// ----------------------------------------------------------------------------
// cacheline_adapter
//   Memory-side responder for the cache's 256-bit line interface. One line
//   read or write from the cache becomes a 4 x 64-bit burst on the burst
//   memory port; completion is a single-cycle dfp_resp.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   dfp_addr        : line address from cache (byte offset ignored)
//   dfp_read/write  : line requests, held by the cache until dfp_resp
//   dfp_wdata       : write line
//   dfp_rdata       : assembled read line, updated only when a read completes
//   dfp_resp        : one-cycle completion pulse
//   bmem_addr       : line-aligned burst base address
//   bmem_read       : burst read command, held until bmem_ready
//   bmem_write      : write beat valid, held per beat until bmem_ready
//   bmem_wdata      : current write beat
//   bmem_ready      : memory accepts command/beat this cycle
//   bmem_raddr      : base address of returning read data
//   bmem_rdata      : read beat
//   bmem_rvalid     : read beat valid (ignored outside RD_DATA)
//   err             : sticky returned-address mismatch flag
//
// Configuration
//   CACHELINE_ADAPTER_RADDR_CHECK_EN : when defined, every read beat whose
//   bmem_raddr differs from the latched line address sets err (sticky until
//   rst); the beat is still stored. When undefined, err is tied low.
// ----------------------------------------------------------------------------
module cacheline_adapter
  import cacheline_adapter_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid,
  output logic                  err
);

  adapter_state_t        state_r,      state_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_r,        cnt_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic [LINE_WIDTH-1:0] line_r,       line_nxt_s;
  logic [LINE_WIDTH-1:0] wdata_r,      wdata_nxt_s;
  logic [LINE_WIDTH-1:0] dfp_rdata_r,  dfp_rdata_nxt_s;
  logic                  dfp_resp_r,   dfp_resp_nxt_s;
  logic [ADDR_WIDTH-1:0] bmem_addr_r,  bmem_addr_nxt_s;
  logic                  bmem_read_r,  bmem_read_nxt_s;
  logic                  bmem_write_r, bmem_write_nxt_s;
  logic [BEAT_WIDTH-1:0] bmem_wdata_r, bmem_wdata_nxt_s;

  logic is_last_s;

  // Counter is exactly log2(BEATS) wide, so the increment wraps to 0 after the last beat.
  assign cnt_inc_s = cnt_r + CNT_WIDTH'(1);
  assign is_last_s = (cnt_r == LAST_BEAT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (dfp_read) begin
          state_nxt_s = RD_REQ;
        end else if (dfp_write) begin
          state_nxt_s = WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_nxt_s = RD_DATA;
        end else begin
          state_nxt_s = RD_REQ;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid && is_last_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = RD_DATA;
        end
      end
      WR: begin
        if (bmem_ready && is_last_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WR;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output/datapath logic: next values for every registered output and datapath register.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    line_nxt_s       = line_r;
    wdata_nxt_s      = wdata_r;
    dfp_rdata_nxt_s  = dfp_rdata_r;
    dfp_resp_nxt_s   = 1'b0;
    bmem_addr_nxt_s  = bmem_addr_r;
    bmem_read_nxt_s  = bmem_read_r;
    bmem_write_nxt_s = bmem_write_r;
    bmem_wdata_nxt_s = bmem_wdata_r;
    case (state_r)
      IDLE: begin
        if (dfp_read) begin
          bmem_addr_nxt_s = line_align(dfp_addr);
          bmem_read_nxt_s = 1'b1;
          cnt_nxt_s       = '0;
        end else if (dfp_write) begin
          bmem_addr_nxt_s  = line_align(dfp_addr);
          wdata_nxt_s      = dfp_wdata;
          bmem_write_nxt_s = 1'b1;
          bmem_wdata_nxt_s = dfp_wdata[BEAT_WIDTH-1:0];
          cnt_nxt_s        = '0;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          bmem_read_nxt_s = 1'b0;
          cnt_nxt_s       = '0;
        end else begin
          bmem_read_nxt_s = 1'b1;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          line_nxt_s[cnt_r*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          cnt_nxt_s = cnt_inc_s;
          // The final beat is merged combinationally so dfp_rdata is complete in the RESP cycle.
          if (is_last_s) begin
            dfp_rdata_nxt_s = line_nxt_s;
            dfp_resp_nxt_s  = 1'b1;
          end else begin
            dfp_resp_nxt_s  = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      WR: begin
        if (bmem_ready) begin
          cnt_nxt_s = cnt_inc_s;
          if (is_last_s) begin
            bmem_write_nxt_s = 1'b0;
            dfp_resp_nxt_s   = 1'b1;
          end else begin
            bmem_wdata_nxt_s = wdata_r[cnt_inc_s*BEAT_WIDTH +: BEAT_WIDTH];
          end
        end else begin
          bmem_write_nxt_s = 1'b1;
        end
      end
      RESP: begin
        cnt_nxt_s = '0;
      end
      default: begin
        cnt_nxt_s        = '0;
        bmem_read_nxt_s  = 1'b0;
        bmem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      line_r       <= '0;
      wdata_r      <= '0;
      dfp_rdata_r  <= '0;
      dfp_resp_r   <= 1'b0;
      bmem_addr_r  <= '0;
      bmem_read_r  <= 1'b0;
      bmem_write_r <= 1'b0;
      bmem_wdata_r <= '0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      line_r       <= line_nxt_s;
      wdata_r      <= wdata_nxt_s;
      dfp_rdata_r  <= dfp_rdata_nxt_s;
      dfp_resp_r   <= dfp_resp_nxt_s;
      bmem_addr_r  <= bmem_addr_nxt_s;
      bmem_read_r  <= bmem_read_nxt_s;
      bmem_write_r <= bmem_write_nxt_s;
      bmem_wdata_r <= bmem_wdata_nxt_s;
    end
  end

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  logic err_r, err_nxt_s;

  // Sticky mismatch flag: set by any accepted read beat tagged with a foreign base address.
  always_comb begin
    err_nxt_s = err_r;
    if ((state_r == RD_DATA) && bmem_rvalid && (bmem_raddr != bmem_addr_r)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Mismatch flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
    end
  end

  assign err = err_r;
`else
  // Returned address is not inspected in this build.
  logic raddr_unused_s;
  assign raddr_unused_s = ^bmem_raddr;
  assign err            = 1'b0;
`endif

  assign dfp_rdata  = dfp_rdata_r;
  assign dfp_resp   = dfp_resp_r;
  assign bmem_addr  = bmem_addr_r;
  assign bmem_read  = bmem_read_r;
  assign bmem_write = bmem_write_r;
  assign bmem_wdata = bmem_wdata_r;

endmodule
